// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the rf_ctrl instruction sequencer: state and
// instruction-class enums, opcode/op constants, write-back selects and the
// bit positions of every instruction field.
package rf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_WR_REG,
        ST_WR_IMM,
        ST_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_MOVI,
        CLS_MOVR,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_MVN,
        CLS_ILLEGAL
    } iclass_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;
    localparam int RN_MSB  = 10;
    localparam int RN_LSB  = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 5;
    localparam int SH_MSB  = 4;
    localparam int SH_LSB  = 3;
    localparam int RM_MSB  = 2;
    localparam int RM_LSB  = 0;

endpackage

// File: rtl/rf_ctrl_decode.sv
// Combinational instruction classifier: maps the opcode and op fields of the
// held instruction onto an instruction class and flags unsupported encodings.
module rf_ctrl_decode
    import rf_ctrl_pkg::*;
(
    input  logic [2:0] opcode_i,
    input  logic [1:0] op_i,
    output iclass_e    class_o,
    output logic       illegal_o
);

    // Anything not explicitly recognised falls through as illegal
    always_comb begin
        class_o   = CLS_ILLEGAL;
        illegal_o = 1'b1;
        if (opcode_i == OPC_MOV) begin
            if (op_i == MOV_IMM) begin
                class_o   = CLS_MOVI;
                illegal_o = 1'b0;
            end else if (op_i == MOV_REG) begin
                class_o   = CLS_MOVR;
                illegal_o = 1'b0;
            end
        end else if (opcode_i == OPC_ALU) begin
            illegal_o = 1'b0;
            case (op_i)
                ALU_ADD: class_o = CLS_ADD;
                ALU_CMP: class_o = CLS_CMP;
                ALU_AND: class_o = CLS_AND;
                default: class_o = CLS_MVN;
            endcase
        end
    end

endmodule

// File: rtl/rf_ctrl.sv
// rf_ctrl: multi-cycle sequencer driving the 8x16 register file and ALU
// datapath, one instruction at a time over a valid/ready handshake.
// Optional feature macro RF_CTRL_ILLEGAL_TRAP_EN: illegal encodings park the
// controller in a sticky TRAP state with the 'illegal' port raised; without
// it, illegal encodings retire as a one-cycle NOP.
module rf_ctrl
    import rf_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  alu_op,
    output logic [1:0]  shift,
    output logic        done
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    iclass_e     decClass;
    logic        decIllegal;
    logic [2:0]  rn, rd, rm;

    assign rn = ir_q[RN_MSB:RN_LSB];
    assign rd = ir_q[RD_MSB:RD_LSB];
    assign rm = ir_q[RM_MSB:RM_LSB];

    rf_ctrl_decode uDecode (
        .opcode_i  (ir_q[OPC_MSB:OPC_LSB]),
        .op_i      (ir_q[OP_MSB:OP_LSB]),
        .class_o   (decClass),
        .illegal_o (decIllegal)
    );

    assign ir_d   = (in_valid && in_ready) ? in_instr : ir_q;
    assign alu_op = ir_q[OP_MSB:OP_LSB];
    assign shift  = ir_q[SH_MSB:SH_LSB];
    assign bsel   = 1'b0;

`ifdef RF_CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state_q == ST_TRAP);
`endif

    // Sequencer state register; reset drops every strobe immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register, captured only on a completed handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    // Next-state and per-state strobes; register indices idle at Rm/Rd
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        readnum  = rm;
        writenum = rd;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = VSEL_C;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (decIllegal) begin
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    done    = 1'b1;
                    state_d = ST_IDLE;
`endif
                end else begin
                    case (decClass)
                        CLS_MOVI: state_d = ST_WR_IMM;
                        CLS_ADD,
                        CLS_CMP,
                        CLS_AND:  state_d = ST_GET_A;
                        CLS_MOVR,
                        CLS_MVN:  state_d = ST_GET_B;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = ST_GET_B;
            end
            ST_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                asel = (decClass == CLS_MOVR) || (decClass == CLS_MVN);
                if (decClass == CLS_CMP) begin
                    loads   = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    loadc   = 1'b1;
                    state_d = ST_WR_REG;
                end
            end
            ST_WR_REG: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
                done     = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_WR_IMM: begin
                writenum = rn;
                vsel     = VSEL_IMM;
                write    = 1'b1;
                done     = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_TRAP: begin
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
                state_d = ST_TRAP;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rf_ctrl.sv
// Self-checking bench for rf_ctrl. An instruction-level model turns every
// accepted instruction into its expected per-cycle output schedule and keeps
// an ISA-level register file; a compare process checks the DUT every cycle.
// Honours RF_CTRL_ILLEGAL_TRAP_EN like the design does.
module tb_rf_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0000;
    logic        in_ready;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel, done;
    logic [1:0]  vsel, alu_op, shift;
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    rf_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .alu_op   (alu_op),
        .shift    (shift),
        .done     (done)
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal  (illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rdN;
        logic [2:0]  wrN;
        logic        write;
        logic        la;
        logic        lb;
        logic        lc;
        logic        ls;
        logic        asel;
        logic [1:0]  vsel;
        logic        done;
        logic [15:0] wdata;
    } step_t;

    step_t       sched[$];
    logic [15:0] modelIr = 16'h0000;
    logic [15:0] modelRegs [8];
    bit          modelTrap = 1'b0;
    bit          trapPending = 1'b0;
    bit          acceptedEdge = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic step_t idleStep(input logic [15:0] w);
        step_t s;
        s.rdN   = w[2:0];
        s.wrN   = w[7:5];
        s.write = 1'b0;
        s.la    = 1'b0;
        s.lb    = 1'b0;
        s.lc    = 1'b0;
        s.ls    = 1'b0;
        s.asel  = 1'b0;
        s.vsel  = 2'b00;
        s.done  = 1'b0;
        s.wdata = 16'h0000;
        return s;
    endfunction

    function automatic logic [15:0] shiftVal(input logic [15:0] v, input logic [1:0] sh);
        case (sh)
            2'b00:   return v;
            2'b01:   return {v[14:0], 1'b0};
            2'b10:   return {1'b0, v[15:1]};
            default: return {v[15], v[15:1]};
        endcase
    endfunction

    // Expand one accepted instruction into the cycles it must occupy
    task automatic buildSchedule(input logic [15:0] w);
        logic [2:0]  opc = w[15:13];
        logic [1:0]  op  = w[12:11];
        logic [2:0]  rn  = w[10:8];
        logic [2:0]  rd  = w[7:5];
        logic [2:0]  rm  = w[2:0];
        logic [15:0] a   = modelRegs[rn];
        logic [15:0] b   = shiftVal(modelRegs[rm], w[4:3]);
        bit          isAlu  = (opc == 3'b101);
        bit          isMovi = (opc == 3'b110) && (op == 2'b10);
        bit          isMovr = (opc == 3'b110) && (op == 2'b00);
        step_t       s;
        s = idleStep(w);
        if (!isAlu && !isMovi && !isMovr) begin
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
            trapPending = 1'b1;
`else
            s.done = 1'b1;
`endif
            sched.push_back(s);
            return;
        end
        sched.push_back(s);
        if (isMovi) begin
            s = idleStep(w);
            s.wrN = rn; s.vsel = 2'b01; s.write = 1'b1; s.done = 1'b1;
            s.wdata = {{8{w[7]}}, w[7:0]};
            sched.push_back(s);
            return;
        end
        if (isAlu && op != 2'b11) begin
            s = idleStep(w);
            s.rdN = rn; s.la = 1'b1;
            sched.push_back(s);
        end
        s = idleStep(w);
        s.rdN = rm; s.lb = 1'b1;
        sched.push_back(s);
        s = idleStep(w);
        s.asel = isMovr || (isAlu && op == 2'b11);
        if (isAlu && op == 2'b01) begin
            s.ls = 1'b1; s.done = 1'b1;
            sched.push_back(s);
            return;
        end
        s.lc = 1'b1;
        sched.push_back(s);
        s = idleStep(w);
        s.wrN = rd; s.write = 1'b1; s.done = 1'b1;
        if (isMovr)             s.wdata = b;
        else if (op == 2'b00)   s.wdata = a + b;
        else if (op == 2'b10)   s.wdata = a & b;
        else                    s.wdata = ~b;
        sched.push_back(s);
    endtask

    // Reference model: advances one schedule step per clock edge
    initial begin
        step_t s;
        for (int i = 0; i < 8; i++) modelRegs[i] = 16'h0000;
        forever begin
            @(posedge clk or negedge rst_n);
            acceptedEdge = 1'b0;
            if (!rst_n) begin
                sched.delete();
                modelIr     = 16'h0000;
                modelTrap   = 1'b0;
                trapPending = 1'b0;
            end else if (sched.size() > 0) begin
                s = sched.pop_front();
                if (s.write) modelRegs[s.wrN] = s.wdata;
                if (sched.size() == 0 && trapPending) begin
                    modelTrap   = 1'b1;
                    trapPending = 1'b0;
                end
            end else if (!modelTrap && in_valid) begin
                modelIr      = in_instr;
                acceptedEdge = 1'b1;
                buildSchedule(in_instr);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model
    initial begin
        step_t e;
        forever begin
            @(negedge clk);
            if (sched.size() > 0) e = sched[0];
            else                  e = idleStep(modelIr);
            checkOutput("in_ready", 16'(in_ready), 16'(sched.size() == 0 && !modelTrap));
            checkOutput("readnum",  16'(readnum),  16'(e.rdN));
            checkOutput("writenum", 16'(writenum), 16'(e.wrN));
            checkOutput("write",    16'(write),    16'(e.write));
            checkOutput("loada",    16'(loada),    16'(e.la));
            checkOutput("loadb",    16'(loadb),    16'(e.lb));
            checkOutput("loadc",    16'(loadc),    16'(e.lc));
            checkOutput("loads",    16'(loads),    16'(e.ls));
            checkOutput("asel",     16'(asel),     16'(e.asel));
            checkOutput("bsel",     16'(bsel),     16'h0000);
            checkOutput("vsel",     16'(vsel),     16'(e.vsel));
            checkOutput("alu_op",   16'(alu_op),   16'(modelIr[12:11]));
            checkOutput("shift",    16'(shift),    16'(modelIr[4:3]));
            checkOutput("done",     16'(done),     16'(e.done));
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
            checkOutput("illegal",  16'(illegal),  16'(modelTrap));
`endif
        end
    end

    // Present an instruction and hold it until the model accepts it
    task automatic applyStimulus(input logic [15:0] w, input bit hold);
        int n = 0;
        in_valid = 1'b1;
        in_instr = w;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!acceptedEdge && n < 100);
        if (!acceptedEdge) begin
            errors++;
            $display("[TB] FAIL accept_timeout: instr %h not accepted within %0d cycles", w, n);
        end
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (sched.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sched.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle_timeout: %0d steps still pending", sched.size());
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] randInstr();
        logic [15:0] w = 16'($urandom);
        int k;
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
        k = $urandom_range(0, 2);
`else
        k = $urandom_range(0, 3);
`endif
        case (k)
            0: w[15:11] = 5'b11010;
            1: w[15:11] = 5'b11000;
            2: w[15:13] = 3'b101;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    w[15:13] = 3'b110;
                    w[11]    = 1'b1;
                end else begin
                    while (w[15:13] == 3'b110 || w[15:13] == 3'b101) w[15:13] = 3'($urandom);
                end
            end
        endcase
        return w;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // MOV R1,#7
        applyStimulus(16'hD107, 1'b0);
        @(negedge clk); checkOutput("movi_c1_done", 16'(done), 16'h0000);
        @(negedge clk);
        checkOutput("movi_writenum", 16'(writenum), 16'h0001);
        checkOutput("movi_vsel",     16'(vsel),     16'h0001);
        checkOutput("movi_write",    16'(write),    16'h0001);
        checkOutput("movi_done",     16'(done),     16'h0001);
        @(negedge clk); checkOutput("movi_ready", 16'(in_ready), 16'h0001);
        checkOutput("model_r1", modelRegs[1], 16'h0007);

        // MOV R2,#2 then ADD R3,R1,R2
        applyStimulus(16'hD202, 1'b0);
        waitIdle();
        applyStimulus(16'hA162, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("add_geta_rd", 16'(readnum), 16'h0001);
        checkOutput("add_loada",   16'(loada),   16'h0001);
        @(negedge clk);
        checkOutput("add_getb_rd", 16'(readnum), 16'h0002);
        checkOutput("add_loadb",   16'(loadb),   16'h0001);
        @(negedge clk); checkOutput("add_loadc", 16'(loadc), 16'h0001);
        @(negedge clk);
        checkOutput("add_writenum", 16'(writenum), 16'h0003);
        checkOutput("add_write",    16'(write),    16'h0001);
        @(negedge clk); checkOutput("add_ready", 16'(in_ready), 16'h0001);
        checkOutput("model_r3", modelRegs[3], 16'h0009);

        // CMP R1,R1
        applyStimulus(16'hA901, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("cmp_loads", 16'(loads), 16'h0001);
        checkOutput("cmp_done",  16'(done),  16'h0001);
        checkOutput("cmp_write", 16'(write), 16'h0000);
        waitIdle();

        // MVN R7,R1 with in_valid held high
        applyStimulus(16'hB8E1, 1'b1);
        @(negedge clk);
        @(negedge clk); checkOutput("mvn_loadb", 16'(loadb), 16'h0001);
        @(negedge clk); checkOutput("mvn_asel",  16'(asel),  16'h0001);
        @(negedge clk);
        checkOutput("mvn_writenum", 16'(writenum), 16'h0007);
        checkOutput("mvn_write",    16'(write),    16'h0001);
        @(negedge clk); checkOutput("mvn_ready", 16'(in_ready), 16'h0001);
        @(negedge clk); checkOutput("mvn_reaccept", 16'(in_ready), 16'h0000);
        #2 in_valid = 1'b0;
        waitIdle();
        checkOutput("model_r7", modelRegs[7], 16'hFFF8);

        // Illegal encoding
        applyStimulus(16'hE000, 1'b0);
`ifdef RF_CTRL_ILLEGAL_TRAP_EN
        @(negedge clk); checkOutput("ill_c1_done", 16'(done), 16'h0000);
        @(negedge clk);
        checkOutput("ill_flag",  16'(illegal),  16'h0001);
        checkOutput("ill_ready", 16'(in_ready), 16'h0000);
        repeat (5) @(negedge clk);
        checkOutput("ill_sticky", 16'(illegal), 16'h0001);
        #2 rst_n = 1'b0;
        #1 checkOutput("ill_rst_clear", 16'(illegal), 16'h0000);
        @(negedge clk);
        #2 rst_n = 1'b1;
`else
        @(negedge clk);
        checkOutput("ill_done",  16'(done),  16'h0001);
        checkOutput("ill_write", 16'(write), 16'h0000);
        @(negedge clk); checkOutput("ill_ready", 16'(in_ready), 16'h0001);
`endif
        waitIdle();

        // Reset asserted during WR_REG of ADD R4,R1,R2
        applyStimulus(16'hA182, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("rst_pre_write", 16'(write), 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_write_drop", 16'(write),    16'h0000);
        checkOutput("rst_ready",      16'(in_ready), 16'h0001);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("model_r4_kept", modelRegs[4], 16'h0000);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            if (in_valid && acceptedEdge) in_valid = 1'b0;
            if (!in_valid && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b1;
                in_instr = randInstr();
            end
        end
        in_valid = 1'b0;
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
